axi_master_unpacker: RTL and testbench

AXI_MASTER_UNPACKER -- requirements
Module: axi_master_unpacker

---
 rtl/tc_axi_pkg.sv | 29 ++
 rtl/axi_beat_assembler.sv | 50 +++++
 rtl/axi_master_unpacker.sv | 189 ++++++++++++++++++
 tb/tb_axi_master_unpacker.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_axi_pkg.sv
// ---------------------------------------------------------------------------
// tc_axi_pkg
// Shared definitions for the AXI read-side unpacker and the write-side packer.
//   state_t     : load/store sequencer states
//   BURST_INCR  : AXI4 incrementing burst encoding
//   RESP_OKAY   : AXI4 OKAY response encoding
//   clog2_min1  : ceil(log2(v)), never less than 1, for sizing counters
// ---------------------------------------------------------------------------
package tc_axi_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      AXI_AR     = 3'd1,
      AXI_R      = 3'd2,
      SRAM_WR    = 3'd3,
      CHECK_DONE = 3'd4
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // A counter for a single item still needs one bit, so clamp at 1.
   function automatic int clog2_min1(input int v);
      int w;
      w = $clog2(v);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axi_beat_assembler.sv
// ---------------------------------------------------------------------------
// axi_beat_assembler
// Collects BEATS consecutive AXI data beats into one wide row buffer.
// Beat k lands in row[k*BEAT_WIDTH +: BEAT_WIDTH].
//   clk, rst_n  : clock, asynchronous active-low reset
//   beat_clear  : restart the beat counter at zero (start of a burst)
//   beat_valid  : a beat is being accepted this cycle
//   beat_data   : the beat payload
//   row_full    : the beat accepted this cycle is the last one of the row
//   row         : assembled row buffer
// ---------------------------------------------------------------------------
module axi_beat_assembler
   import tc_axi_pkg::*;
#(
   parameter int BEAT_WIDTH = 64,
   parameter int BEATS      = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        beat_clear,
   input  logic                        beat_valid,
   input  logic [BEAT_WIDTH-1:0]       beat_data,
   output logic                        row_full,
   output logic [BEATS*BEAT_WIDTH-1:0] row
);

   localparam int CNT_W = clog2_min1(BEATS);

   logic [CNT_W-1:0] beat_cnt;

   // row_full is qualified by beat_valid so the sequencer can use it directly
   // both to leave the data phase and to cross-check the incoming rlast.
   assign row_full = beat_valid && (beat_cnt == CNT_W'(BEATS - 1));

   // Store each accepted beat at the slot selected by the beat counter; the
   // counter rolls back to zero after the last beat so a new row starts clean
   // even if beat_clear is not pulsed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         row      <= '0;
      end else if (beat_clear) begin
         beat_cnt <= '0;
      end else if (beat_valid) begin
         row[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
         beat_cnt <= row_full ? '0 : beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/axi_master_unpacker.sv
// ---------------------------------------------------------------------------
// axi_master_unpacker
// Loads reg_m_len rows from DDR into SRAM. Each row is one AXI4 INCR burst
// of BEATS beats; the beats are assembled into ARRAY_WIDTH lanes and written
// to the SRAM in a single cycle. One burst is outstanding at a time.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start_load                 : start pulse, honoured only when idle
//   load_done_irq              : one-cycle completion pulse
//   load_err                   : sticky error (bad rresp or misplaced rlast)
//   busy                       : sequencer not idle
//   reg_ddr_addr/m_len/addr_a  : DDR base, row count, SRAM base row
//   wr_en/wr_addr/wr_data      : SRAM row write port
//   ar*/r*                     : AXI4 read address and read data channels
// ---------------------------------------------------------------------------
module axi_master_unpacker
   import tc_axi_pkg::*;
#(
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int SRAM_DATA_WIDTH = 32,
   parameter int ARRAY_WIDTH     = 16,
   parameter int ADDR_WIDTH      = 10
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start_load,
   output logic                                   load_done_irq,
   output logic                                   load_err,
   output logic                                   busy,
   input  logic [63:0]                            reg_ddr_addr,
   input  logic [31:0]                            reg_m_len,
   input  logic [31:0]                            reg_addr_a,
   output logic                                   wr_en,
   output logic [ADDR_WIDTH-1:0]                  wr_addr,
   output logic [ARRAY_WIDTH*SRAM_DATA_WIDTH-1:0] wr_data,
   output logic [31:0]                            araddr,
   output logic [7:0]                             arlen,
   output logic [2:0]                             arsize,
   output logic [1:0]                             arburst,
   output logic                                   arvalid,
   input  logic                                   arready,
   input  logic [AXI_DATA_WIDTH-1:0]              rdata,
   input  logic [1:0]                             rresp,
   input  logic                                   rlast,
   input  logic                                   rvalid,
   output logic                                   rready
);

   localparam int          BEATS       = SRAM_DATA_WIDTH * ARRAY_WIDTH / AXI_DATA_WIDTH;
   localparam logic [31:0] ROW_BYTES   = 32'(BEATS * AXI_DATA_WIDTH / 8);
   localparam logic [7:0]  ARLEN_VAL   = 8'(BEATS - 1);

   state_t                  state;
   state_t                  state_next;
   logic                    irq_next;
   logic [31:0]             ddr_addr;
   logic [ADDR_WIDTH-1:0]   sram_row;
   logic [31:0]             row_cnt;
   logic [31:0]             row_cnt_inc;
   logic [31:0]             m_len;
   logic                    beat_valid;
   logic                    beat_clear;
   logic                    row_full;
   logic                    unused_bits;

   // Only the low address bits are meaningful to this block.
   assign unused_bits = ^{reg_ddr_addr[63:32], reg_addr_a[31:ADDR_WIDTH]};

   assign arsize      = 3'($clog2(AXI_DATA_WIDTH / 8));
   assign arburst     = BURST_INCR;
   assign araddr      = ddr_addr;
   assign arvalid     = (state == AXI_AR);
   assign rready      = (state == AXI_R);
   assign wr_en       = (state == SRAM_WR);
   assign wr_addr     = sram_row;
   assign busy        = (state != IDLE);
   assign beat_valid  = rvalid && rready;
   assign beat_clear  = (state == AXI_AR) && arready;
   assign row_cnt_inc = row_cnt + 32'd1;

   // The row buffer's flat layout already matches the lane order, so the
   // SRAM write data is the buffer itself.
   axi_beat_assembler #(
      .BEAT_WIDTH (AXI_DATA_WIDTH),
      .BEATS      (BEATS)
   ) u_assembler (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_clear (beat_clear),
      .beat_valid (beat_valid),
      .beat_data  (rdata),
      .row_full   (row_full),
      .row        (wr_data)
   );

   // State register for the load sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A zero-length load never leaves IDLE but still raises
   // the completion pulse, so software sees the same handshake either way.
   always_comb begin
      state_next = state;
      irq_next   = 1'b0;
      case (state)
         IDLE: begin
            if (start_load) begin
               if (reg_m_len == 32'd0) begin
                  irq_next = 1'b1;
               end else begin
                  state_next = AXI_AR;
               end
            end
         end
         AXI_AR: begin
            if (arready) begin
               state_next = AXI_R;
            end
         end
         AXI_R: begin
            if (row_full) begin
               state_next = SRAM_WR;
            end
         end
         SRAM_WR: begin
            state_next = CHECK_DONE;
         end
         CHECK_DONE: begin
            if (row_cnt_inc >= m_len) begin
               state_next = IDLE;
               irq_next   = 1'b1;
            end else begin
               state_next = AXI_AR;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Load bookkeeping: latch the job on start, flag protocol errors during
   // the data phase without stalling, and advance addresses once per row.
   // The row count is latched so a register rewrite mid-load cannot change
   // the job length. arlen sits at zero in reset and is the constant burst
   // length from the first clock afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ddr_addr      <= '0;
         sram_row      <= '0;
         row_cnt       <= '0;
         m_len         <= '0;
         load_err      <= 1'b0;
         load_done_irq <= 1'b0;
         arlen         <= '0;
      end else begin
         arlen         <= ARLEN_VAL;
         load_done_irq <= irq_next;
         case (state)
            IDLE: begin
               if (start_load) begin
                  ddr_addr <= reg_ddr_addr[31:0];
                  sram_row <= reg_addr_a[ADDR_WIDTH-1:0];
                  row_cnt  <= '0;
                  m_len    <= reg_m_len;
                  load_err <= 1'b0;
               end
            end
            AXI_R: begin
               if (beat_valid && ((rresp != RESP_OKAY) || (rlast != row_full))) begin
                  load_err <= 1'b1;
               end
            end
            CHECK_DONE: begin
               ddr_addr <= ddr_addr + ROW_BYTES;
               sram_row <= sram_row + ADDR_WIDTH'(1);
               row_cnt  <= row_cnt_inc;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_master_unpacker.sv
// ---------------------------------------------------------------------------
// tb_axi_master_unpacker
// Self-checking bench: an AXI read slave model feeds beats whose lane values
// encode (row, lane); a monitor records AR handshakes, SRAM writes and irqs;
// the main sequence compares them with expectations queued at start time.
// ---------------------------------------------------------------------------
module tb_axi_master_unpacker;

   localparam int OBS_MAX = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_load;
   logic         load_done_irq;
   logic         load_err;
   logic         busy;
   logic [63:0]  reg_ddr_addr;
   logic [31:0]  reg_m_len;
   logic [31:0]  reg_addr_a;
   logic         wr_en;
   logic [9:0]   wr_addr;
   logic [511:0] wr_data;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready = 1'b0;
   logic [63:0]  rdata = '0;
   logic [1:0]   rresp = 2'b00;
   logic         rlast = 1'b0;
   logic         rvalid = 1'b0;
   logic         rready;

   axi_master_unpacker dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_load    (start_load),
      .load_done_irq (load_done_irq),
      .load_err      (load_err),
      .busy          (busy),
      .reg_ddr_addr  (reg_ddr_addr),
      .reg_m_len     (reg_m_len),
      .reg_addr_a    (reg_addr_a),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .araddr        (araddr),
      .arlen         (arlen),
      .arsize        (arsize),
      .arburst       (arburst),
      .arvalid       (arvalid),
      .arready       (arready),
      .rdata         (rdata),
      .rresp         (rresp),
      .rlast         (rlast),
      .rvalid        (rvalid),
      .rready        (rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          m_len;
      logic [63:0] ddr;
      logic [31:0] addr_a;
      int          ar_delay;
      bit          r_toggle;
      int          err_beat;
      logic [1:0]  err_resp;
      bit          drop_rlast;
      bit          exp_err;
   } vec_t;

   vec_t vec[7];

   int checks = 0;
   int failures = 0;

   // Slave configuration, written only by the main sequence.
   int         cfg_ar_delay = 0;
   bit         cfg_r_toggle = 1'b0;
   int         cfg_err_beat = -1;
   logic [1:0] cfg_err_resp = 2'b00;
   bit         cfg_drop_rlast = 1'b0;

   // Monitor state, written only by the monitor process.
   bit          ar_hs_seen = 1'b0;
   bit          r_hs_seen = 1'b0;
   bit          ar_hold = 1'b0;
   logic [31:0] ar_hold_addr = '0;
   int          stab_viol = 0;
   int          irq_cnt = 0;
   int          obs_ar_n = 0;
   int          obs_wr_n = 0;
   logic [31:0] obs_ar_addr[OBS_MAX];
   logic [7:0]  obs_ar_len[OBS_MAX];
   logic [9:0]  obs_wr_addr[OBS_MAX];
   logic [511:0] obs_wr_data[OBS_MAX];

   // Scoreboard, owned by the main sequence.
   logic [31:0]  exp_ar[$];
   logic [9:0]   exp_wa[$];
   logic [511:0] exp_wd[$];
   int ar_rd = 0;
   int wr_rd = 0;
   int irq_base = 0;
   int stab_base = 0;

   // Slave state.
   bit r_pending = 1'b0;
   int r_beat = 0;
   int ar_wait = 0;
   int tag = 0;
   bit phase = 1'b0;

   // Sample everything half a cycle away from the DUT's active edge; what is
   // seen here is exactly what the DUT will act on at the next rising edge.
   always @(negedge clk) begin
      ar_hs_seen = arvalid && arready;
      r_hs_seen  = rvalid && rready;
      if (rst_n) begin
         if (ar_hold && !(arvalid && (araddr == ar_hold_addr))) stab_viol++;
         ar_hold      = arvalid && !arready;
         ar_hold_addr = araddr;
         if (arvalid && arready && obs_ar_n < OBS_MAX) begin
            obs_ar_addr[obs_ar_n] = araddr;
            obs_ar_len[obs_ar_n]  = arlen;
            obs_ar_n++;
         end
         if (wr_en && obs_wr_n < OBS_MAX) begin
            obs_wr_addr[obs_wr_n] = wr_addr;
            obs_wr_data[obs_wr_n] = wr_data;
            obs_wr_n++;
         end
         if (load_done_irq) irq_cnt++;
      end else begin
         ar_hold = 1'b0;
      end
   end

   // AXI read slave: optional arready delay, optional rvalid toggling, and
   // beat k of burst 'tag' carries lanes tag*16+2k (low) and tag*16+2k+1.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
         r_pending = 1'b0; r_beat = 0; ar_wait = 0; tag = 0;
      end else begin
         if (!busy) tag = 0;
         if (ar_hs_seen) begin
            arready = 1'b0; r_pending = 1'b1; r_beat = 0; ar_wait = 0;
         end else if (arvalid && !arready) begin
            if (ar_wait >= cfg_ar_delay) arready = 1'b1;
            else ar_wait++;
         end
         if (r_hs_seen && r_pending) begin
            r_beat++;
            if (r_beat == 8) begin
               r_pending = 1'b0;
               tag++;
            end
         end
         if (r_pending) begin
            phase  = ~phase;
            rvalid = cfg_r_toggle ? phase : 1'b1;
            rdata  = {32'(tag*16 + 2*r_beat + 1), 32'(tag*16 + 2*r_beat)};
            rresp  = (r_beat == cfg_err_beat) ? cfg_err_resp : 2'b00;
            rlast  = (r_beat == 7) && !cfg_drop_rlast;
         end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Queue the AR addresses and SRAM rows a load should produce, then pulse
   // start_load for one cycle.
   task automatic applyStimulus(input vec_t v);
      logic [511:0] d;
      cfg_ar_delay   = v.ar_delay;
      cfg_r_toggle   = v.r_toggle;
      cfg_err_beat   = v.err_beat;
      cfg_err_resp   = v.err_resp;
      cfg_drop_rlast = v.drop_rlast;
      reg_m_len      = 32'(v.m_len);
      reg_ddr_addr   = v.ddr;
      reg_addr_a     = v.addr_a;
      for (int r = 0; r < v.m_len; r++) begin
         exp_ar.push_back(32'(v.ddr[31:0] + 32'(r * 64)));
         exp_wa.push_back(10'(v.addr_a[9:0] + 10'(r)));
         for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(r*16 + i);
         exp_wd.push_back(d);
      end
      irq_base  = irq_cnt;
      stab_base = stab_viol;
      start_load = 1'b1;
      step();
      start_load = 1'b0;
      if (v.m_len > 0) checkOutput({v.name, " busy after start"}, busy, 1);
   endtask

   task automatic waitIrq(input string name);
      int n = 0;
      while (irq_cnt == irq_base && n < 400) begin
         step();
         n++;
      end
      checkOutput({name, " irq seen in time"}, (irq_cnt != irq_base), 1);
   endtask

   task automatic checkTransfers(input string name);
      checkOutput({name, " ar count"}, obs_ar_n - ar_rd, exp_ar.size());
      while (exp_ar.size() > 0 && ar_rd < obs_ar_n) begin
         checkOutput({name, " araddr"}, obs_ar_addr[ar_rd], exp_ar.pop_front());
         checkOutput({name, " arlen"}, obs_ar_len[ar_rd], 8'd7);
         ar_rd++;
      end
      checkOutput({name, " write count"}, obs_wr_n - wr_rd, exp_wa.size());
      while (exp_wa.size() > 0 && wr_rd < obs_wr_n) begin
         checkOutput({name, " wr_addr"}, obs_wr_addr[wr_rd], exp_wa.pop_front());
         checkOutput({name, " wr_data"}, obs_wr_data[wr_rd], exp_wd.pop_front());
         wr_rd++;
      end
      exp_ar.delete();
      exp_wa.delete();
      exp_wd.delete();
      ar_rd = obs_ar_n;
      wr_rd = obs_wr_n;
      checkOutput({name, " ar stable while waiting"}, stab_viol - stab_base, 0);
   endtask

   task automatic runVector(input vec_t v);
      applyStimulus(v);
      waitIrq(v.name);
      repeat (2) step();
      checkOutput({v.name, " irq pulses"}, irq_cnt - irq_base, 1);
      checkOutput({v.name, " load_err"}, load_err, v.exp_err);
      checkOutput({v.name, " busy at end"}, busy, 0);
      checkTransfers(v.name);
   endtask

   initial begin
      vec_t hv;
      rst_n = 1'b0;
      start_load = 1'b0;
      reg_ddr_addr = '0;
      reg_m_len = '0;
      reg_addr_a = '0;

      //            name           m_len ddr             addr_a dly tog errb resp  drop err
      vec[0] = '{"single row",     1, 64'h1000,     32'd5,    0, 0, -1, 2'b00, 0, 0};
      vec[1] = '{"three rows",     3, 64'h2000,     32'd0,    0, 0, -1, 2'b00, 0, 0};
      vec[2] = '{"wait states",    1, 64'h1000,     32'd5,    4, 1, -1, 2'b00, 0, 0};
      vec[3] = '{"slverr beat3",   1, 64'h3000,     32'd7,    0, 0,  3, 2'b10, 0, 1};
      vec[4] = '{"row wrap",       2, 64'h4000,     32'd1023, 0, 0, -1, 2'b00, 0, 0};
      vec[5] = '{"ddr wrap",       2, 64'hFFFFFFC0, 32'd10,   1, 0, -1, 2'b00, 0, 0};
      vec[6] = '{"missing rlast",  1, 64'h8000,     32'd40,   0, 0, -1, 2'b00, 1, 1};

      repeat (3) step();
      checkOutput("reset busy", busy, 0);
      checkOutput("reset arvalid", arvalid, 0);
      checkOutput("reset rready", rready, 0);
      checkOutput("reset wr_en", wr_en, 0);
      checkOutput("reset irq", load_done_irq, 0);
      checkOutput("reset load_err", load_err, 0);
      checkOutput("reset araddr", araddr, 0);
      checkOutput("reset arlen", arlen, 0);
      checkOutput("reset wr_addr", wr_addr, 0);
      checkOutput("reset wr_data", wr_data, 0);
      rst_n = 1'b1;
      step();
      checkOutput("arsize", arsize, 3'b011);
      checkOutput("arburst", arburst, 2'b01);

      for (int v = 0; v < 7; v++) runVector(vec[v]);

      // Zero-length load: completion pulse exactly one cycle after start.
      irq_base  = irq_cnt;
      stab_base = stab_viol;
      reg_m_len = 32'd0;
      start_load = 1'b1;
      step();
      start_load = 1'b0;
      checkOutput("mlen0 irq after 1 cycle", load_done_irq, 1);
      checkOutput("mlen0 busy", busy, 0);
      step();
      checkOutput("mlen0 irq is one cycle", load_done_irq, 0);
      repeat (5) step();
      checkOutput("mlen0 irq pulses", irq_cnt - irq_base, 1);
      checkTransfers("mlen0");

      // A second start while busy must not restart or extend the load.
      hv = '{"busy ignore", 1, 64'h6000, 32'd20, 0, 0, -1, 2'b00, 0, 0};
      applyStimulus(hv);
      repeat (3) step();
      reg_m_len = 32'd4;
      reg_ddr_addr = 64'h7000;
      reg_addr_a = 32'd30;
      start_load = 1'b1;
      step();
      start_load = 1'b0;
      reg_m_len = 32'd1;
      reg_ddr_addr = 64'h6000;
      reg_addr_a = 32'd20;
      waitIrq(hv.name);
      repeat (10) step();
      checkOutput("busy ignore irq pulses", irq_cnt - irq_base, 1);
      checkTransfers(hv.name);

      // Reset in the middle of the second burst aborts the load silently.
      hv = '{"reset abort", 2, 64'h5000, 32'd1023, 0, 0, -1, 2'b00, 0, 0};
      applyStimulus(hv);
      begin
         int n = 0;
         while (obs_ar_n < ar_rd + 2 && n < 200) begin
            step();
            n++;
         end
      end
      checkOutput("reset abort second AR reached", obs_ar_n - ar_rd, 2);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      checkOutput("mid reset busy", busy, 0);
      checkOutput("mid reset arvalid", arvalid, 0);
      checkOutput("mid reset rready", rready, 0);
      checkOutput("mid reset wr_en", wr_en, 0);
      checkOutput("mid reset irq", load_done_irq, 0);
      checkOutput("mid reset load_err", load_err, 0);
      checkOutput("mid reset araddr", araddr, 0);
      checkOutput("mid reset arlen", arlen, 0);
      checkOutput("mid reset wr_addr", wr_addr, 0);
      checkOutput("mid reset wr_data", wr_data, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (20) step();
      void'(exp_wa.pop_back());
      void'(exp_wd.pop_back());
      checkOutput("reset abort irq pulses", irq_cnt - irq_base, 0);
      checkOutput("reset abort busy", busy, 0);
      checkTransfers(hv.name);

      // Normal operation resumes after the aborted load.
      hv = vec[0];
      hv.name = "after reset";
      runVector(hv);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
